// File: rtl/sample_packer_if.sv
// sample_packer_if: byte stream in, packed-word stream and counters out.
interface sample_packer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [7:0]  mode;
    logic        enable;
    logic [15:0] out_data;
    logic        out_en;
    logic [15:0] word_count;
    logic [7:0]  pad_count;
    modport master (output in_data, in_valid, mode, enable,
                    input  out_data, out_en, word_count, pad_count);
    modport slave  (input  in_data, in_valid, mode, enable,
                    output out_data, out_en, word_count, pad_count);
endinterface

// File: rtl/sample_packer.sv
// sample_packer: packs mode-selected sample bytes into 16-bit words, byte-aligned across mode and enable changes.
module sample_packer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  PAD_BYTE      = 8'h00
) (
    input  logic            source_clk,
    input  logic            source_reset_n,
    sample_packer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    state_t      state, state_d;
    logic        phase, phase_d;
    logic [7:0]  hi, hi_d, mode_q, mode_q_d;
    logic [3:0]  cnt, cnt_d;
    logic        emit, pad;
    logic [15:0] word_d;
    always_comb begin
        state_d  = state;
        phase_d  = phase;
        hi_d     = hi;
        mode_q_d = mode_q;
        cnt_d    = cnt;
        emit     = 1'b0;
        pad      = 1'b0;
        word_d   = '0;
        if (state == IDLE) begin
            if (bus.enable) begin
                state_d  = SETTLE;
                cnt_d    = SETTLE_LD;
                mode_q_d = bus.mode;
            end
        end else if (!bus.enable || bus.mode != mode_q) begin
            // close a half-word with padding so no word spans two modes
            if (state == RUN && phase) begin
                emit   = 1'b1;
                pad    = 1'b1;
                word_d = {hi, PAD_BYTE};
            end
            phase_d  = 1'b0;
            cnt_d    = SETTLE_LD;
            mode_q_d = bus.mode;
            state_d  = bus.enable ? SETTLE : IDLE;
        end else if (bus.in_valid) begin
            if (state == SETTLE) begin
                cnt_d = cnt - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = RUN;
                    phase_d = 1'b0;
                end
            end else if (!phase) begin
                hi_d    = bus.in_data;
                phase_d = 1'b1;
            end else begin
                emit    = 1'b1;
                word_d  = {hi, bus.in_data};
                phase_d = 1'b0;
            end
        end
    end
    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            state          <= IDLE;
            phase          <= 1'b0;
            hi             <= '0;
            mode_q         <= '0;
            cnt            <= '0;
            bus.out_data   <= '0;
            bus.out_en     <= 1'b0;
            bus.word_count <= '0;
            bus.pad_count  <= '0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            hi         <= hi_d;
            mode_q     <= mode_q_d;
            cnt        <= cnt_d;
            bus.out_en <= emit;
            if (emit) begin
                bus.out_data   <= word_d;
                bus.word_count <= bus.word_count + 16'd1;
            end
            if (pad && bus.pad_count != 8'hFF)
                bus.pad_count <= bus.pad_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: randomized and directed stimulus against a queue-based reference model with a scoreboard monitor.
module tb_sample_packer;
    localparam int         SETTLE = 2;
    localparam logic [7:0] PAD    = 8'h00;
    typedef struct {logic [15:0] w; logic [15:0] wc; logic [7:0] pc;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    sample_packer_if bus();
    sample_packer #(.SETTLE_CYCLES(SETTLE), .PAD_BYTE(PAD)) dut (
        .source_clk(clk), .source_reset_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int vecs = 0;
    int errs = 0;
    exp_t q[$];
    logic [7:0] pend[$];
    bit active = 0;
    int skip = 0;
    logic [7:0] mq = 0;
    logic [15:0] exp_wc = 0;
    logic [7:0] exp_pc = 0;
    task automatic push_word(input logic [15:0] w, input bit padded);
        exp_wc = exp_wc + 16'd1;
        if (padded && exp_pc != 8'hFF) exp_pc = exp_pc + 8'd1;
        q.push_back('{w, exp_wc, exp_pc});
    endtask
    // words are pairs of accepted bytes; a lone byte at a mode/enable boundary gets padded
    task automatic model(input logic v, input logic [7:0] d, input logic en, input logic [7:0] m);
        if (!active) begin
            if (en) begin active = 1; skip = SETTLE; mq = m; end
        end else if (!en || m != mq) begin
            if (pend.size() == 1) push_word({pend[0], PAD}, 1);
            pend.delete();
            active = en;
            skip = SETTLE;
            mq = m;
        end else if (v) begin
            if (skip > 0) skip--;
            else begin
                pend.push_back(d);
                if (pend.size() == 2) begin
                    push_word({pend[0], pend[1]}, 0);
                    pend.delete();
                end
            end
        end
    endtask
    task automatic model_reset();
        q.delete(); pend.delete();
        active = 0; skip = 0; mq = 0; exp_wc = 0; exp_pc = 0;
    endtask
    task automatic step(input logic v, input logic [7:0] d, input logic en, input logic [7:0] m);
        @(negedge clk);
        bus.in_valid = v; bus.in_data = d; bus.enable = en; bus.mode = m;
        model(v, d, en, m);
    endtask
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.out_en === 1'b1) begin
            vecs++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_word got %h expected none", bus.out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.out_data !== e.w || bus.word_count !== e.wc || bus.pad_count !== e.pc) begin
                    errs++;
                    $display("FAIL word got %h/%0d/%0d expected %h/%0d/%0d",
                             bus.out_data, bus.word_count, bus.pad_count, e.w, e.wc, e.pc);
                end
            end
        end
    end
    initial begin
        logic en;
        logic [7:0] m;
        bus.in_valid = 0; bus.in_data = 0; bus.enable = 0; bus.mode = 0;
        repeat (3) @(negedge clk);
        chk("reset_out_data", 32'(bus.out_data), 0);
        chk("reset_out_en", 32'(bus.out_en), 0);
        chk("reset_word_count", 32'(bus.word_count), 0);
        chk("reset_pad_count", 32'(bus.pad_count), 0);
        rst_n = 1'b1;
        step(0, 8'h00, 1, 0);
        for (int i = 1; i <= 6; i++) step(1, 8'(i), 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("t1_word_count", 32'(bus.word_count), 2);
        step(1, 8'hAA, 1, 0); step(1, 8'hBB, 1, 0); step(1, 8'hCC, 1, 0);
        step(1, 8'hDD, 1, 3);
        step(0, 8'h00, 1, 3);
        chk("t2_pad_count", 32'(bus.pad_count), 1);
        step(1, 8'h01, 1, 3); step(1, 8'h02, 1, 3);
        step(1, 8'h5A, 1, 3);
        step(1, 8'h77, 0, 3);
        for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 3);
        step(0, 8'h00, 1, 3); step(1, 8'h01, 1, 3); step(1, 8'h02, 1, 3);
        step(1, 8'h11, 1, 3); step(0, 8'h99, 1, 3); step(1, 8'h22, 1, 3); step(0, 8'h98, 1, 3);
        step(1, 8'h33, 1, 3);
        step(1, 8'h44, 1, 3);
        step(1, 8'h55, 1, 3);
        chk("t6_out_en_before_reset", 32'(bus.out_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_out_data", 32'(bus.out_data), 0);
        chk("t6_async_out_en", 32'(bus.out_en), 0);
        chk("t6_async_word_count", 32'(bus.word_count), 0);
        chk("t6_async_pad_count", 32'(bus.pad_count), 0);
        model_reset();
        @(negedge clk);
        bus.in_valid = 0; bus.enable = 0; bus.mode = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 0);
        step(1, 8'h44, 1, 0);
        step(1, 8'h55, 1, 0); step(1, 8'h66, 1, 0); step(1, 8'h77, 1, 0); step(1, 8'h88, 1, 0);
        step(0, 8'h00, 1, 0); step(0, 8'h00, 1, 0);
        chk("t6_restart_word_count", 32'(bus.word_count), 1);
        m = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 8'($urandom), 1, m); step(1, 8'($urandom), 1, m);
            step(1, 8'($urandom), 1, m);
            m = m ^ 8'h01;
            step(1, 8'($urandom), 1, m);
        end
        step(0, 8'h00, 1, m); step(0, 8'h00, 1, m);
        chk("t5_pad_saturated", 32'(bus.pad_count), 32'hFF);
        en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) en = ~en;
            if ($urandom_range(39) == 0) m = 8'($urandom_range(3));
            step(($urandom_range(9) < 7), 8'($urandom), en, m);
        end
        repeat (3) step(0, 8'h00, en, m);
        chk("drain_queue_empty", 32'(q.size()), 0);
        chk("final_word_count", 32'(bus.word_count), 32'(exp_wc));
        chk("final_pad_count", 32'(bus.pad_count), 32'(exp_pc));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
